// File: rtl/piso_shift_tx_amisha.sv
// Parallel-in/serial-out transmitter with valid/ready word load.
// Shifts one bit per enabled clock and pulses done after the last bit.
module piso_shift_tx_amisha #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_amisha,
  input  logic             reset_n_amisha,
  input  logic             en_amisha,
  input  logic             load_valid_amisha,
  input  logic [WIDTH-1:0] load_data_amisha,
  output logic             load_ready_amisha,
  output logic             sout_amisha,
  output logic             sout_valid_amisha,
  output logic             busy_amisha,
  output logic             done_amisha
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             done_q;
  logic             done_d;
  logic [WIDTH-1:0] shifted;

  // Zero fill so the register drains to 0 by the time the word ends.
  assign shifted = MSB_FIRST ?
    {shreg_q[WIDTH-2:0], 1'b0} :
    {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (load_valid_amisha) begin
          shreg_d = load_data_amisha;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      (state_q == SHIFT): begin
        if (en_amisha) begin
          shreg_d = shifted;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign load_ready_amisha = (state_q == IDLE);
  assign busy_amisha       = (state_q == SHIFT);
  assign sout_valid_amisha = (state_q == SHIFT);
  assign done_amisha       = done_q;
  assign sout_amisha       = (state_q == SHIFT) &&
    (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_shift_tx_amisha.sv
// Scoreboard bench for piso_shift_tx_amisha.
// Two instances share stimulus: index 0 MSB-first, index 1 LSB-first.
module tb_piso_shift_tx_amisha;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic [1:0]   load_ready;
  logic [1:0]   sout;
  logic [1:0]   sout_valid;
  logic [1:0]   busy;
  logic [1:0]   done;

  int n_pass;
  int n_total;
  int en_mode;

  bit bq[2][$];
  bit lq[2][$];
  bit exp_done[2];

  piso_shift_tx_amisha #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk_amisha       (clk),
    .reset_n_amisha   (rst_n),
    .en_amisha        (en),
    .load_valid_amisha(load_valid),
    .load_data_amisha (load_data),
    .load_ready_amisha(load_ready[0]),
    .sout_amisha      (sout[0]),
    .sout_valid_amisha(sout_valid[0]),
    .busy_amisha      (busy[0]),
    .done_amisha      (done[0])
  );

  piso_shift_tx_amisha #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk_amisha       (clk),
    .reset_n_amisha   (rst_n),
    .en_amisha        (en),
    .load_valid_amisha(load_valid),
    .load_data_amisha (load_data),
    .load_ready_amisha(load_ready[1]),
    .sout_amisha      (sout[1]),
    .sout_valid_amisha(sout_valid[1]),
    .busy_amisha      (busy[1]),
    .done_amisha      (done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: a word is the list of its bits in transmission order.
  task automatic push_word(input int d, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      int b;
      b = (d == 0) ? (W - 1 - i) : i;
      bq[d].push_back(bit'((w >> b) & 1));
      lq[d].push_back(i == W - 1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        bit in_flight;
        in_flight = (bq[d].size() != 0);
        chk($sformatf("sout_valid%0d", d), 32'(sout_valid[d]), 32'(in_flight));
        chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(in_flight));
        chk($sformatf("ready%0d", d), 32'(load_ready[d]), 32'(!in_flight));
        chk($sformatf("done%0d", d), 32'(done[d]), 32'(exp_done[d]));
        if (in_flight)
          chk($sformatf("sout%0d", d), 32'(sout[d]), 32'(bq[d][0]));
        else
          chk($sformatf("sout_idle%0d", d), 32'(sout[d]), 32'd0);
        exp_done[d] = 1'b0;
        if (in_flight && en) begin
          void'(bq[d].pop_front());
          if (lq[d].pop_front()) exp_done[d] = 1'b1;
        end
        if (!in_flight && load_valid) push_word(d, load_data);
      end
    end
  end

  initial begin
    en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0: en = 1'b1;
        1: en = ~en;
        2: en = ($urandom_range(3) != 0);
        default: en = 1'b0;
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"}, 32'(load_ready[d]), 32'd1);
      chk({tag, "_sout"}, 32'(sout[d]), 32'd0);
      chk({tag, "_valid"}, 32'(sout_valid[d]), 32'd0);
      chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
      chk({tag, "_done"}, 32'(done[d]), 32'd0);
    end
  endtask

  task automatic send(input logic [W-1:0] w);
    bit ok;
    ok = 1'b0;
    load_valid = 1'b1;
    load_data  = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (load_ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      bq[d].delete();
      lq[d].delete();
      exp_done[d] = 1'b0;
    end
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    en_mode    = 0;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    #3;
    check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    en_mode = 0;
    send(8'hA5);
    wait_idle();

    en_mode = 1;
    send(8'hA5);
    wait_idle();

    en_mode = 0;
    send(8'hA5);
    repeat (3) @(posedge clk);
    en_mode = 3;
    repeat (10) @(posedge clk);
    en_mode = 0;
    wait_idle();

    send(8'hA5);
    send(8'h3C);
    wait_idle();

    send(8'h01);
    send(8'h80);
    wait_idle();

    send(8'hFF);
    repeat (3) @(posedge clk);
    do_reset();
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    send(8'h0F);
    wait_idle();

    en_mode = 2;
    for (int k = 0; k < 40; k++) begin
      send(W'($urandom));
      if ($urandom_range(1) == 0) begin
        repeat ($urandom_range(12)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained0", 32'(bq[0].size()), 32'd0);
    chk("queue_drained1", 32'(bq[1].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
